alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, registered ALU for the RISC-V datapath. Extends the core
//   ADD/SUB/AND/OR/SLT set with XOR, SLTU, shifts and an iterative unsigned
//   multiplier. Operands enter through a valid/ready handshake. Results and
//   flags leave through a one-entry output register with its own handshake.
//   Sits between operand select and writeback in the multi-cycle core.
// PARAMETERS
//   WIDTH   32  datapath width in bits; >=8; power of two
//   MUL_EN  1   1: MUL/MULHU are implemented; 0: MUL codes act as undefined codes
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   in_valid    in   1      A, B and ALUControl are valid
//   in_ready    out  1      block can accept an operation this cycle
//   A           in   WIDTH  operand A
//   B           in   WIDTH  operand B; shift amount = B[$clog2(WIDTH)-1:0]
//   ALUControl  in   4      operation code (table below)
//   out_valid   out  1      Result and flags are valid
//   out_ready   in   1      consumer takes the result this cycle
//   Result      out  WIDTH  registered result
//   Z,N,V,C     out  1 each registered flags
//   busy        out  1      multiply is in progress
// BEHAVIOUR
//   Clock and reset: one clock, clk. rst is synchronous and active-high.
//   Op codes: 0000 ADD  0001 SUB  0010 AND  0011 OR  0100 XOR  0101 SLT
//     0110 SLTU  0111 SLL  1000 SRL  1001 SRA  1010 MUL (low WIDTH bits)
//     1011 MULHU (high WIDTH bits of unsigned 2*WIDTH product).
//     Any other code: Result=0, latency 1.
//   Arithmetic rules:
//     SUB is A + ~B + 1.
//     SLT = N^V of A-B, a correct signed compare that includes overflow.
//     SLTU = ~carry of A-B.
//     SLT and SLTU write the compare bit into Result[0] and zero-extend it.
//   Flags:
//     Z = (Result==0). N = Result[WIDTH-1].
//     C = carry out for ADD/SUB; for SUB, C=1 means no borrow.
//     V = signed overflow for ADD/SUB.
//     C=V=0 for every other op.
//   Handshake:
//     An op is accepted on a cycle with in_valid && in_ready.
//     in_ready = !rst && state==IDLE && (!out_valid || out_ready).
//     Output transfer happens on out_valid && out_ready.
//     While out_valid && !out_ready, Result and flags hold stable.
//   FSM (IDLE, MUL):
//     IDLE, accept a non-MUL op: Result and flags load at the next edge,
//       out_valid=1 (latency 1). State stays IDLE. Back-to-back ops give
//       1 result per cycle when out_ready=1.
//     IDLE, accept MUL/MULHU with MUL_EN=1: latch A and B, clear the
//       2*WIDTH accumulator, cnt=0, go to MUL. busy=1.
//     MUL: one shift-add step per cycle, cnt++.
//       On the step with cnt==WIDTH-1: load Result and flags, out_valid=1,
//       go to IDLE, busy=0.
//       Latency is WIDTH cycles from the accept edge to out_valid.
//       in_ready=0 for the whole of MUL.
//   Output register: drained on the accept cycle if it was valid
//     (in_ready requires out_ready). It is therefore empty when MUL completes.
//     A drain with no new accept clears out_valid.
//   Reset: all of the following are 0 on the edge where rst=1 —
//     out_valid, Result, Z, N, V, C, busy, cnt, and the accumulator.
//     State goes to IDLE. rst in mid-MUL aborts with no output.
//     in_ready=0 while rst=1.
//   Wrap-around: ADD/SUB wrap modulo 2^WIDTH. Shift amounts use only the
//     low $clog2(WIDTH) bits of B. MUL discards the high half of the product.
// TESTING (WIDTH=32)
//   1. ADD 7FFFFFFF+1 -> next cycle Result=80000000, N=1, V=1, C=0, Z=0.
//   2. SUB 5-5 -> Result=0, Z=1, C=1.
//      SLT FFFFFFFF,1 -> 1.
//      SLTU FFFFFFFF,1 -> 0.
//      SLT 80000000,7FFFFFFF -> 1 (overflow case).
//   3. SRA F0000000 by 0x24 (amount 4) -> FF000000.
//      SRL same inputs -> 0F000000.
//      SLL 1 by 31 -> 80000000.
//   4. MUL FFFFFFFF*FFFFFFFF -> out_valid exactly 32 cycles after accept,
//      Result=00000001. MULHU same inputs -> FFFFFFFE.
//      in_ready=0 and busy=1 throughout.
//   5. Backpressure: out_ready=0 for 3 cycles after ADD 2+3.
//      Required: Result=5 held stable and in_ready=0.
//      Then out_ready=1 with SUB 9-4 -> 5 transfers, next cycle Result=5.
//   6. Assert rst at MUL step 10 -> next cycle out_valid=0, busy=0.
//      After release, ADD 1+1 -> 2 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered RISC-V ALU with a valid/ready operand port, a one-entry output register
// and an iterative shift-add unsigned multiplier (MUL / MULHU).
module alu_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C,
  output logic             busy
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpSlt   = 4'b0101;
  localparam logic [3:0] OpSltu  = 4'b0110;
  localparam logic [3:0] OpSll   = 4'b0111;
  localparam logic [3:0] OpSrl   = 4'b1000;
  localparam logic [3:0] OpSra   = 4'b1001;
  localparam logic [3:0] OpMul   = 4'b1010;
  localparam logic [3:0] OpMulhu = 4'b1011;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   res_q;
  logic               z_q, n_q, v_q, c_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [SW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               mulhi_q;

  logic accept;
  logic is_mul;

  assign in_ready = !rst && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && ((ALUControl == OpMul) || (ALUControl == OpMulhu));

  // Single-cycle ALU datapath
  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    sub_sum;
  logic              add_v;
  logic              sub_v;
  logic              slt;
  logic              sltu;
  logic [SW-1:0]     shamt;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c;
  logic              alu_v;

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
  assign slt     = sub_sum[WIDTH-1] ^ sub_v;
  assign sltu    = ~sub_sum[WIDTH];
  assign shamt   = B[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OpAdd: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_v;
      end
      OpSub: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = sub_v;
      end
      OpAnd:   alu_res = A & B;
      OpOr:    alu_res = A | B;
      OpXor:   alu_res = A ^ B;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, sltu};
      OpSll:   alu_res = A << shamt;
      OpSrl:   alu_res = A >> shamt;
      OpSra:   alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the high half, shift the whole product right
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_res;

  assign partial  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
  assign acc_step = {partial, acc_q[WIDTH-1:1]};
  assign mul_res  = mulhi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      res_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mulhi_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && is_mul) begin
            a_q         <= A;
            b_q         <= B;
            acc_q       <= '0;
            cnt_q       <= '0;
            mulhi_q     <= (ALUControl == OpMulhu);
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= StMul;
          end else if (accept) begin
            res_q       <= alu_res;
            z_q         <= (alu_res == '0);
            n_q         <= alu_res[WIDTH-1];
            v_q         <= alu_v;
            c_q         <= alu_c;
            out_valid_q <= 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StMul: begin
          acc_q <= acc_step;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + SW'(1);
          if (cnt_q == SW'(WIDTH - 1)) begin
            res_q       <= mul_res;
            z_q         <= (mul_res == '0);
            n_q         <= mul_res[WIDTH-1];
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign Result    = res_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign C         = c_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [3:0]    op_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic          Z, N, V, C;
  logic          busy;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a_in),
    .B          (b_in),
    .ALUControl (op_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Z          (Z),
    .N          (N),
    .V          (V),
    .C          (C),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed/unsigned arithmetic on wide integers
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    longint      sa, sb, s;
    logic [63:0] p;
    int unsigned amt;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = 32'(b[4:0]);
    p   = {32'b0, a} * {32'b0, b};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      4'd0: begin
        r = a + b;
        s = sa + sb;
        c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b;
        s = sa - sb;
        c = (a >= b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  r = a << amt;
      4'd8:  r = a >> amt;
      4'd9:  r = 32'(sa >>> amt);
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      default: r = '0;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] er;
    logic        ec, ev;
    int          lat, exp_lat, guard;
    bit          hold_ok;
    model(op, a, b, er, ec, ev);
    // edges from presenting the op: accept edge plus WIDTH shift-add steps for multiplies
    exp_lat = (op == 4'd10 || op == 4'd11) ? W + 1 : 1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    check_eq({tag, "_rdy"}, in_ready, 1);
    op_in    = op;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 1;
    hold_ok  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) hold_ok = 1'b0;
      step();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, Result, er);
    check_eq({tag, "_zvnc"}, {Z, N, V, C}, {er == 32'd0, er[31], ev, ec});
    if (exp_lat > 1) check_eq({tag, "_busy"}, hold_ok, 1);
  endtask

  logic [3:0]  d_op [13] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd5, 4'd9, 4'd8, 4'd7,
                             4'd10, 4'd11, 4'd1, 4'd13, 4'd0};
  logic [31:0] d_a  [13] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'hF000_0000, 32'hF000_0000, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
  logic [31:0] d_b  [13] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'h24, 32'h24, 32'd31,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h9, 32'd1};
  logic [31:0] edge_v [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFE};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_in     = '0;
    a_in      = '0;
    b_in      = '0;
    step();
    step();
    check_eq("rst_ovalid", out_valid, 0);
    check_eq("rst_result", Result, 0);
    check_eq("rst_flags", {Z, N, V, C}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_inready", in_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_inready", in_ready, 1);

    for (int i = 0; i < 13; i++) do_op(d_op[i], d_a[i], d_b[i], $sformatf("dir%0d", i));

    // Backpressure: ADD result must hold while a pending SUB waits
    step();
    out_ready = 1'b0;
    op_in = 4'd0; a_in = 32'd2; b_in = 32'd3; in_valid = 1'b1;
    step();
    op_in = 4'd1; a_in = 32'd9; b_in = 32'd4;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bp_res%0d", i), {out_valid, Result}, {1'b1, 32'd5});
      check_eq($sformatf("bp_rdy%0d", i), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("bp_sub", {out_valid, Result, C}, {1'b1, 32'd5, 1'b1});
    step();
    check_eq("bp_drained", out_valid, 0);

    // Reset in the middle of a multiply
    op_in = 4'd10; a_in = 32'd3; b_in = 32'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    check_eq("abort_ovalid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_inready", in_ready, 0);
    rst = 1'b0;
    #1;
    do_op(4'd0, 32'd1, 32'd1, "after_rst");
    for (int i = 0; i < 40; i++) step();
    check_eq("no_late_mul", out_valid, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      do_op(rop, pick(), pick(), $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
